vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 95 +++++++++
 tb/tb_vga_sync_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running line/frame counters with a registered decode of
// sync, active-area flag, 1-based active coordinates and a frame-start pulse.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        SYNC_COLOR,
  output logic [10:0] Current_X,
  output logic [10:0] Current_Y,
  output logic        oFRAME_START
);

  localparam int unsigned HTotal = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned VTotal = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

  localparam logic [10:0] HLast     = 11'(HTotal - 1);
  localparam logic [10:0] VLast     = 11'(VTotal - 1);
  localparam logic [10:0] HSyncEnd  = 11'(H_SYNC);
  localparam logic [10:0] VSyncEnd  = 11'(V_SYNC);
  localparam logic [10:0] HActStart = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] VActStart = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] HActEnd   = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] VActEnd   = 11'(V_SYNC + V_BACK + V_VISIBLE);

  logic [10:0] r_h_cnt, r_v_cnt;
  logic        r_hs, r_vs, r_color, r_fs;
  logic [10:0] r_x, r_y;

  logic        w_h_wrap, w_v_wrap;
  logic [10:0] w_h_nxt, w_v_nxt;
  logic        w_hs, w_vs, w_h_act, w_v_act, w_color, w_fs;
  logic [10:0] w_x, w_y;

  always_comb begin
    w_h_wrap = (r_h_cnt == HLast);
    w_v_wrap = (r_v_cnt == VLast);
    w_h_nxt  = w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? 11'd0 : r_v_cnt + 11'd1;
    end
  end

  // Decode of the current (pre-edge) count; registered below for one-cycle latency.
  always_comb begin
    w_hs    = (r_h_cnt >= HSyncEnd);
    w_vs    = (r_v_cnt >= VSyncEnd);
    w_h_act = (r_h_cnt >= HActStart) && (r_h_cnt < HActEnd);
    w_v_act = (r_v_cnt >= VActStart) && (r_v_cnt < VActEnd);
    w_color = w_h_act && w_v_act;
    w_x     = w_color ? (r_h_cnt - HActStart + 11'd1) : 11'd0;
    w_y     = w_color ? (r_v_cnt - VActStart + 11'd1) : 11'd0;
    w_fs    = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
  end

  always_ff @(posedge VGA_CLK or negedge RESET) begin
    if (!RESET) begin
      r_h_cnt <= 11'd0;
      r_v_cnt <= 11'd0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_color <= 1'b0;
      r_x     <= 11'd0;
      r_y     <= 11'd0;
      r_fs    <= 1'b0;
    end else begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_hs    <= w_hs;
      r_vs    <= w_vs;
      r_color <= w_color;
      r_x     <= w_x;
      r_y     <= w_y;
      r_fs    <= w_fs;
    end
  end

  assign oVGA_HS      = r_hs;
  assign oVGA_VS      = r_vs;
  assign SYNC_COLOR   = r_color;
  assign Current_X    = r_x;
  assign Current_Y    = r_y;
  assign oFRAME_START = r_fs;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny 7x5 frame on another.
module tb_vga_sync_gen;

  logic clk;
  logic rst_a, rst_b;

  logic        a_hs, a_vs, a_color, a_fs;
  logic [10:0] a_x, a_y;
  logic        b_hs, b_vs, b_color, b_fs;
  logic [10:0] b_x, b_y;

  int checks = 0;
  int errors = 0;
  int edge_a = 0;

  vga_sync_gen u_dut_a (
    .VGA_CLK      (clk),
    .RESET        (rst_a),
    .oVGA_HS      (a_hs),
    .oVGA_VS      (a_vs),
    .SYNC_COLOR   (a_color),
    .Current_X    (a_x),
    .Current_Y    (a_y),
    .oFRAME_START (a_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (1), .H_BACK (1),
    .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) u_dut_b (
    .VGA_CLK      (clk),
    .RESET        (rst_b),
    .oVGA_HS      (b_hs),
    .oVGA_VS      (b_vs),
    .SYNC_COLOR   (b_color),
    .Current_X    (b_x),
    .Current_Y    (b_y),
    .oFRAME_START (b_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: got %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_a++;
  endtask

  task automatic run_to(input int target);
    while (edge_a < target) tick();
  endtask

  task automatic check_a_reset(input int idx);
    check("a_rst_hs", idx, 32'(a_hs), 32'd1);
    check("a_rst_vs", idx, 32'(a_vs), 32'd1);
    check("a_rst_color", idx, 32'(a_color), 32'd0);
    check("a_rst_x", idx, 32'(a_x), 32'd0);
    check("a_rst_y", idx, 32'(a_y), 32'd0);
    check("a_rst_fs", idx, 32'(a_fs), 32'd0);
  endtask

  // Hand tables for the 7x5 frame: sync 1, back 1, active 4 (cols) / 2 (rows), front 1.
  int x_tab [7] = '{0, 0, 1, 2, 3, 4, 0};
  int y_tab [5] = '{0, 0, 1, 2, 0};

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_a_reset(0);
    check("b_rst_hs", 0, 32'(b_hs), 32'd1);
    check("b_rst_fs", 0, 32'(b_fs), 32'd0);
    check("b_rst_x", 0, 32'(b_x), 32'd0);

    @(negedge clk);
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    edge_a = 0;

    // Two full lines on A (HS low 96 / high 704), and two full small frames on B.
    for (int k = 1; k <= 1600; k++) begin
      int h, v;
      tick();
      h = (k - 1) % 800;
      v = (k - 1) / 800;
      check("a_hs", k, 32'(a_hs), (h >= 96) ? 32'd1 : 32'd0);
      check("a_vs", k, 32'(a_vs), (v >= 2) ? 32'd1 : 32'd0);
      check("a_fs", k, 32'(a_fs), (k == 1) ? 32'd1 : 32'd0);
      check("a_color", k, 32'(a_color), 32'd0);
      if (k <= 71) begin
        int d, hb, vb, xe, ye;
        d  = k - 1;
        hb = d % 7;
        vb = (d / 7) % 5;
        xe = (y_tab[vb] != 0) ? x_tab[hb] : 0;
        ye = (x_tab[hb] != 0) ? y_tab[vb] : 0;
        check("b_hs", k, 32'(b_hs), (hb >= 1) ? 32'd1 : 32'd0);
        check("b_vs", k, 32'(b_vs), (vb >= 1) ? 32'd1 : 32'd0);
        check("b_x", k, 32'(b_x), 32'(xe));
        check("b_y", k, 32'(b_y), 32'(ye));
        check("b_color", k, 32'(b_color), (xe != 0) ? 32'd1 : 32'd0);
        check("b_fs", k, 32'(b_fs), (d % 35 == 0) ? 32'd1 : 32'd0);
      end
    end

    // Active-area edges on line v=35 (decoded h appears on edge v*800+h+1).
    run_to(35 * 800 + 143 + 1);
    check("a_pre_color", 143, 32'(a_color), 32'd0);
    check("a_pre_x", 143, 32'(a_x), 32'd0);
    tick();
    check("a_first_color", 144, 32'(a_color), 32'd1);
    check("a_first_x", 144, 32'(a_x), 32'd1);
    check("a_first_y", 144, 32'(a_y), 32'd1);
    run_to(35 * 800 + 783 + 1);
    check("a_last_color", 783, 32'(a_color), 32'd1);
    check("a_last_x", 783, 32'(a_x), 32'd640);
    check("a_last_y", 783, 32'(a_y), 32'd1);
    tick();
    check("a_post_color", 784, 32'(a_color), 32'd0);
    check("a_post_x", 784, 32'(a_x), 32'd0);
    check("a_post_y", 784, 32'(a_y), 32'd0);
    check("a_post_hs", 784, 32'(a_hs), 32'd1);

    // Asynchronous reset between edges, mid-line at decoded (300,36).
    run_to(36 * 800 + 300 + 1);
    check("a_mid_x", 300, 32'(a_x), 32'd157);
    check("a_mid_y", 300, 32'(a_y), 32'd2);
    check("a_mid_color", 300, 32'(a_color), 32'd1);
    #2;
    rst_a = 1'b0;
    #1;
    check_a_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check_a_reset(2);

    @(negedge clk);
    rst_a  = 1'b1;
    edge_a = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      check("a_re_hs", k, 32'(a_hs), (k - 1 >= 96) ? 32'd1 : 32'd0);
      check("a_re_vs", k, 32'(a_vs), 32'd0);
      check("a_re_fs", k, 32'(a_fs), (k == 1) ? 32'd1 : 32'd0);
      check("a_re_x", k, 32'(a_x), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
